btb_update_scheduler: RTL and testbench
=======================================

Name: btb_update_scheduler

Overview:
- Sits between the branch-resolution sources (commit stage and the decode-stage pre-resolver) and the BTB's single write port.
- Buffers update requests in a small register queue and coalesces updates that target the same PC.
- Arbitrates the two sources and drains at most one update per cycle when the BTB is ready.
- Also sequences a software- or pipeline-triggered BTB invalidate sweep through the same write port.

Parameters:
- DEPTH, 4: update queue entries; power of two, at least 2.
- BTB_SIZE, 4096: total BTB entries; the sweep covers BTB_SIZE/2 indices × 2 banks.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- btb_ready  in  1  BTB ready for writes; low during the BTB's own reset clear
- commit_upd  in  btb_update_t  update from commit; `valid` qualifies it
- presolve_upd  in  btb_update_t  update from the pre-resolver; `valid` qualifies it
- flush_req  in  1  single-cycle pulse requesting an invalidate of all BTB entries
- btb_upd  out  btb_update_t  to the BTB write port; `valid` is a one-cycle write strobe
- flush_busy  out  1  high while a sweep is in progress
- queue_full  out  1  all DEPTH entries occupied
- drop  out  1  pulse: at least one valid request was discarded this cycle

Behaviour:
- Reset values: all outputs 0, queue empty, FSM in RUN, sweep counter 0.
- FSM states:
  - RUN: normal operation.
  - SWEEP: entered on flush_req from RUN. Clears the queue in the same cycle as entry.
- Entry match: an incoming request matches a queued entry when pc[31:2] is equal.
- Enqueue (RUN only), evaluated against the queue state at the start of the cycle, after this cycle's pop:
  - On a match, the entry's target and cf are overwritten in place. No new slot is used and queue order is unchanged.
  - Both sources valid with equal pc[31:2]: a single entry is written with commit's data, since commit is architecturally final.
  - Both sources valid needing two slots with only one free: presolve is enqueued, commit is dropped and `drop` pulses.
  - No free slot and no match: the request is dropped and `drop` pulses.
  - A slot freed by a same-cycle pop counts as free.
- Drain (RUN):
  - btb_upd is combinational from the head register.
  - btb_upd.valid = !empty & btb_ready.
  - The head pops in the same cycle btb_upd.valid is asserted.
  - Latency: a request enqueued in cycle N appears on btb_upd in N+1 at the earliest.
  - btb_ready low: nothing pops and the queue continues to accept or coalesce.
- Coalesce into head while it drains: if an incoming request matches the head in the cycle it pops, it is enqueued as a new entry rather than lost.
- SWEEP:
  - Each cycle with btb_ready, emits valid=1, cf=ControlFlow_None ('0), target=0, pc = {counter, 2'b00}.
  - The counter starts at 0 and increments by 1. Its width is $clog2(BTB_SIZE) bits, so bit 0 selects the bank (pc[2]) and the upper bits select the index (pc[..:3]).
  - Counter stalls while btb_ready is low.
  - Returns to RUN after emitting the all-ones count, with counter wrapping to 0.
  - flush_busy = (state == SWEEP).
  - Valid requests arriving during SWEEP are dropped and pulse `drop`.
  - flush_req during SWEEP restarts the counter at 0.
- flush_req in the same cycle as valid requests: the requests are dropped and SWEEP is entered.
- rst mid-sweep or with a non-empty queue: returns to RUN, queue empty, no write issued on the rst cycle.
- Pointer arithmetic: head and tail are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full = (MSBs differ & lower bits equal).
  - empty = (pointers equal).

Optional Feature:
- BTB_UPD_STATS_EN defined: adds two outputs, drop_cnt[31:0] and coalesce_cnt[31:0].
  - Both are saturating counters, cleared by rst.
  - They increment on each dropped request and each in-place merge respectively. A cycle with two events adds 2.
- Undefined: these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package (cpu_defs): btb_update_t (existing), btb_sched_state_e {RUN, SWEEP}, BTB_SCHED_DEPTH default constant.
- Sub-module btb_update_queue: DEPTH-entry register queue with match/overwrite lookup, push ×2, pop ×1, full/empty. The FSM, arbitration and sweep stay in the top.

Test Plan:
- Single update: presolve valid, pc=0x8000_0010, btb_ready=1 → btb_upd.valid in the next cycle with the same pc/target, then queue empty.
- Coalesce: commit pc=0x8000_0020 target=A in cycle 0, commit same pc target=B in cycle 1 with btb_ready=0, then btb_ready=1 → exactly one write, target=B.
- Dual source, one slot: fill 3 entries with btb_ready=0, then both sources valid with distinct PCs → presolve enqueued, `drop`=1 for one cycle, queue_full=1.
- Same-PC collision: both sources valid with pc=0x8000_0040, targets P and C → single entry, target=C.
- Sweep, BTB_SIZE=16: pulse flush_req with 2 entries queued → queue cleared, 16 writes with pc 0x0..0x3C step 4. Toggling btb_ready low for 3 cycles mid-sweep extends flush_busy by exactly 3 cycles.
- Reset mid-sweep: assert rst at sweep count 5 → next cycle flush_busy=0, btb_upd.valid=0, queue empty. A fresh update is then accepted normally.

Source files
------------

// File: rtl/btb_update_scheduler_pkg.sv
// Shared types for the BTB update scheduler: update record, scheduler state, default queue depth.
// Latency: none (types and pure helper functions only).
// Backpressure: n/a.
package cpu_defs;

    // Control-flow class recorded in a BTB entry; None marks the entry as invalid.
    typedef enum logic [1:0] {
        ControlFlow_None   = 2'd0,
        ControlFlow_Branch = 2'd1,
        ControlFlow_Jump   = 2'd2,
        ControlFlow_Return = 2'd3
    } control_flow_e;

    // One BTB write: valid strobe, branch PC, predicted target, control-flow class.
    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic [31:0]   target;
        control_flow_e cf;
    } btb_update_t;

    typedef enum logic {
        RUN   = 1'b0,
        SWEEP = 1'b1
    } btb_sched_state_e;

    localparam int BTB_SCHED_DEPTH = 4;

    // Word-aligned PC tag; two requests are the same BTB entry when these match.
    function automatic logic [29:0] pc_tag(input logic [31:0] pc);
        return pc[31:2];
    endfunction

    // Saturating add of a small event count into a 32-bit statistics counter.
    function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/btb_update_scheduler_queue.sv
// Register queue of pending BTB updates: tag lookup/overwrite, up to two pushes and one pop per cycle.
// Latency: a push is visible at the head one cycle later; lookup and head are combinational.
// Backpressure: none internally; the caller must never push more than o_free entries.
module btb_update_queue
    import cpu_defs::*;
#(
    parameter  int DEPTH = BTB_SCHED_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_pop,
    input  logic [29:0]   i_lk0_tag,
    input  logic [29:0]   i_lk1_tag,
    output logic          o_lk0_hit,
    output logic [AW-1:0] o_lk0_idx,
    output logic          o_lk1_hit,
    output logic [AW-1:0] o_lk1_idx,
    input  logic          i_ow0_vld,
    input  logic [AW-1:0] i_ow0_idx,
    input  logic [31:0]   i_ow0_tgt,
    input  control_flow_e i_ow0_cf,
    input  logic          i_ow1_vld,
    input  logic [AW-1:0] i_ow1_idx,
    input  logic [31:0]   i_ow1_tgt,
    input  control_flow_e i_ow1_cf,
    input  btb_update_t   i_push0,
    input  btb_update_t   i_push1,
    output btb_update_t   o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [PW-1:0] o_free
);

    logic [31:0]   r_pc  [DEPTH];
    logic [31:0]   r_tgt [DEPTH];
    control_flow_e r_cf  [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;

    logic [PW-1:0]    w_count;
    logic             w_pop;
    logic [DEPTH-1:0] w_live;
    logic [AW-1:0]    w_head_idx;
    logic [AW-1:0]    w_tail0;
    logic [AW-1:0]    w_tail1;

    assign w_count    = r_tail - r_head;
    assign o_empty    = (r_head == r_tail);
    assign o_full     = (r_head[AW] != r_tail[AW]) && (r_head[AW-1:0] == r_tail[AW-1:0]);
    assign w_pop      = i_pop && !o_empty;
    assign w_head_idx = r_head[AW-1:0];
    assign w_tail0    = r_tail[AW-1:0];
    assign w_tail1    = r_tail[AW-1:0] + AW'(1);
    // A slot vacated by this cycle's pop is immediately reusable.
    assign o_free     = PW'(DEPTH) - w_count + PW'(w_pop);

    // Occupancy after this cycle's pop; the departing head takes no part in matching.
    always_comb begin
        w_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i] = ({1'b0, AW'(i) - w_head_idx} < w_count) &&
                        !(w_pop && (AW'(i) == w_head_idx));
        end
    end

    // Tag lookup for both sources against the surviving entries; lowest index wins.
    always_comb begin
        o_lk0_hit = 1'b0;
        o_lk0_idx = '0;
        o_lk1_hit = 1'b0;
        o_lk1_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_live[i] && (pc_tag(r_pc[i]) == i_lk0_tag)) begin
                o_lk0_hit = 1'b1;
                o_lk0_idx = AW'(i);
            end
            if (w_live[i] && (pc_tag(r_pc[i]) == i_lk1_tag)) begin
                o_lk1_hit = 1'b1;
                o_lk1_idx = AW'(i);
            end
        end
    end

    // Head entry presented to the drain logic.
    always_comb begin
        o_head        = '0;
        o_head.valid  = !o_empty;
        o_head.pc     = r_pc[w_head_idx];
        o_head.target = r_tgt[w_head_idx];
        o_head.cf     = r_cf[w_head_idx];
    end

    // Pointer update; clear and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + PW'(w_pop);
            r_tail <= r_tail + PW'(i_push0.valid) + PW'(i_push1.valid);
        end
    end

    // Entry storage: in-place merges hit live slots, pushes land at the tail, so they never collide.
    always_ff @(posedge clk) begin
        if (i_ow0_vld) begin
            r_tgt[i_ow0_idx] <= i_ow0_tgt;
            r_cf[i_ow0_idx]  <= i_ow0_cf;
        end
        if (i_ow1_vld) begin
            r_tgt[i_ow1_idx] <= i_ow1_tgt;
            r_cf[i_ow1_idx]  <= i_ow1_cf;
        end
        if (i_push0.valid) begin
            r_pc[w_tail0]  <= i_push0.pc;
            r_tgt[w_tail0] <= i_push0.target;
            r_cf[w_tail0]  <= i_push0.cf;
        end
        if (i_push1.valid) begin
            r_pc[w_tail1]  <= i_push1.pc;
            r_tgt[w_tail1] <= i_push1.target;
            r_cf[w_tail1]  <= i_push1.cf;
        end
    end

endmodule

// File: rtl/btb_update_scheduler.sv
// Schedules commit/pre-resolver BTB updates and invalidate sweeps onto one BTB write port (BTB_UPD_STATS_EN adds drop/coalesce counters).
// Latency: an update enqueued in cycle N is written in N+1 at the earliest; one sweep write per ready cycle.
// Backpressure: btb_ready low stalls drain and sweep; requests are coalesced or, with no room, dropped with a drop pulse.
module btb_update_scheduler
    import cpu_defs::*;
#(
    parameter int DEPTH    = BTB_SCHED_DEPTH,
    parameter int BTB_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btb_ready,
    input  btb_update_t commit_upd,
    input  btb_update_t presolve_upd,
    input  logic        flush_req,
    output btb_update_t btb_upd,
    output logic        flush_busy,
    output logic        queue_full,
    output logic        drop
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [31:0] drop_cnt,
    output logic [31:0] coalesce_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(BTB_SIZE);

    btb_sched_state_e r_state;
    logic [CW-1:0]    r_cnt;

    logic          w_run;
    logic          w_accept;
    logic          w_same;
    logic          w_c_req;
    logic          w_p_req;
    logic          w_c_new;
    logic          w_p_new;
    logic          w_c_ow;
    logic          w_p_ow;
    logic          w_c_push;
    logic          w_p_push;
    logic          w_pop;
    logic          w_clr;
    logic          w_empty;
    logic          w_lk0_hit;
    logic          w_lk1_hit;
    logic [AW-1:0] w_lk0_idx;
    logic [AW-1:0] w_lk1_idx;
    logic [PW-1:0] w_free;
    logic [1:0]    w_drop_n;
    logic [1:0]    w_merge_n;
    btb_update_t   w_head;
    btb_update_t   w_push0;
    btb_update_t   w_push1;

    assign w_run    = (r_state == RUN);
    assign w_accept = !rst && w_run && !flush_req;
    // Same-entry collision: commit is architecturally final, so presolve is absorbed into it.
    assign w_same   = commit_upd.valid && presolve_upd.valid &&
                      (pc_tag(commit_upd.pc) == pc_tag(presolve_upd.pc));
    assign w_c_req  = w_accept && commit_upd.valid;
    assign w_p_req  = w_accept && presolve_upd.valid && !w_same;
    assign w_c_ow   = w_c_req && w_lk0_hit;
    assign w_p_ow   = w_p_req && w_lk1_hit;
    assign w_c_new  = w_c_req && !w_lk0_hit;
    assign w_p_new  = w_p_req && !w_lk1_hit;
    // With a single free slot presolve wins; commit takes a slot only if one is left after it.
    assign w_p_push = w_p_new && (w_free != '0);
    assign w_c_push = w_c_new && (w_free >= (w_p_push ? PW'(2) : PW'(1)));
    // The flush cycle discards the queue, so its head is not written either.
    assign w_pop    = w_accept && !w_empty && btb_ready;
    assign w_clr    = !rst && w_run && flush_req;

    assign flush_busy = (r_state == SWEEP);
    assign drop       = (w_drop_n != 2'd0);
    assign w_merge_n  = {1'b0, w_c_ow} + {1'b0, w_p_ow};

    // Number of valid requests discarded this cycle.
    always_comb begin
        w_drop_n = 2'd0;
        if (rst) begin
            w_drop_n = 2'd0;
        end else if (w_accept) begin
            w_drop_n = {1'b0, w_c_new && !w_c_push} + {1'b0, w_p_new && !w_p_push};
        end else begin
            w_drop_n = {1'b0, commit_upd.valid} + {1'b0, presolve_upd.valid};
        end
    end

    // Push ordering: presolve first when it is pushed, commit fills the next slot.
    always_comb begin
        w_push0       = commit_upd;
        if (w_p_push) begin
            w_push0 = presolve_upd;
        end
        w_push0.valid = w_p_push || w_c_push;
        w_push1       = commit_upd;
        w_push1.valid = w_p_push && w_c_push;
    end

    // Write port mux: queue head in RUN, invalidating sweep write in SWEEP, nothing during rst.
    always_comb begin
        btb_upd = '0;
        if (w_pop) begin
            btb_upd       = w_head;
            btb_upd.valid = 1'b1;
        end else if (!rst && (r_state == SWEEP) && btb_ready) begin
            btb_upd.valid = 1'b1;
            btb_upd.pc    = {{(30 - CW){1'b0}}, r_cnt, 2'b00};
        end
    end

    // Mode FSM and sweep counter; the counter stalls on !btb_ready and wraps to 0 on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (flush_req) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                    end
                end
                SWEEP: begin
                    if (flush_req) begin
                        r_cnt <= '0;
                    end else if (btb_ready) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == '1) begin
                            r_state <= RUN;
                        end
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTB_UPD_STATS_EN
    // Saturating event counters for dropped requests and in-place merges.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt     <= '0;
            coalesce_cnt <= '0;
        end else begin
            drop_cnt     <= sat_add32(drop_cnt, w_drop_n);
            coalesce_cnt <= sat_add32(coalesce_cnt, w_merge_n);
        end
    end
`endif

    btb_update_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_pop     (w_pop),
        .i_lk0_tag (pc_tag(commit_upd.pc)),
        .i_lk1_tag (pc_tag(presolve_upd.pc)),
        .o_lk0_hit (w_lk0_hit),
        .o_lk0_idx (w_lk0_idx),
        .o_lk1_hit (w_lk1_hit),
        .o_lk1_idx (w_lk1_idx),
        .i_ow0_vld (w_c_ow),
        .i_ow0_idx (w_lk0_idx),
        .i_ow0_tgt (commit_upd.target),
        .i_ow0_cf  (commit_upd.cf),
        .i_ow1_vld (w_p_ow),
        .i_ow1_idx (w_lk1_idx),
        .i_ow1_tgt (presolve_upd.target),
        .i_ow1_cf  (presolve_upd.cf),
        .i_push0   (w_push0),
        .i_push1   (w_push1),
        .o_head    (w_head),
        .o_full    (queue_full),
        .o_empty   (w_empty),
        .o_free    (w_free)
    );

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed bench for btb_update_scheduler (DEPTH=4, BTB_SIZE=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each comparison is an immediate assertion that counts and reports a miscompare.
module tb_btb_update_scheduler;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        btb_ready;
    logic        flush_req;
    logic        flush_busy;
    logic        queue_full;
    logic        drop;
    btb_update_t commit_upd;
    btb_update_t presolve_upd;
    btb_update_t btb_upd;
`ifdef BTB_UPD_STATS_EN
    logic [31:0] drop_cnt;
    logic [31:0] coalesce_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_pc  [5] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_0204, 32'h0000_0400};
    logic [31:0] exp_tgt [5] = '{32'h0000_0001, 32'h0000_0099, 32'h0000_0003, 32'h0000_0005, 32'h0000_0006};

    always #5 clk = ~clk;

    btb_update_scheduler #(
        .DEPTH    (4),
        .BTB_SIZE (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btb_ready    (btb_ready),
        .commit_upd   (commit_upd),
        .presolve_upd (presolve_upd),
        .flush_req    (flush_req),
        .btb_upd      (btb_upd),
        .flush_busy   (flush_busy),
        .queue_full   (queue_full),
        .drop         (drop)
`ifdef BTB_UPD_STATS_EN
        ,
        .drop_cnt     (drop_cnt),
        .coalesce_cnt (coalesce_cnt)
`endif
    );

    function automatic btb_update_t mk(input logic v, input logic [31:0] pc,
                                       input logic [31:0] tg, input control_flow_e cf);
        btb_update_t u;
        u.valid  = v;
        u.pc     = pc;
        u.target = tg;
        u.cf     = cf;
        return u;
    endfunction

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        commit_upd   = '0;
        presolve_upd = '0;
        flush_req    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int wr;
        rst       = 1'b1;
        btb_ready = 1'b1;
        idle();

        // Reset: a request during rst is neither written nor reported as dropped.
        tick();
        commit_upd = mk(1'b1, 32'h8000_0000, 32'h1, ControlFlow_Branch);
        @(negedge clk);
        chk("rst_drop", 67'(drop), 67'(0));
        chk("rst_upd", 67'(btb_upd), 67'(0));
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("reset_upd", 67'(btb_upd), 67'(0));
        chk("reset_busy", 67'(flush_busy), 67'(0));
        chk("reset_full", 67'(queue_full), 67'(0));
        chk("reset_drop", 67'(drop), 67'(0));

        // Single update: written one cycle after enqueue, then queue empty.
        tick();
        presolve_upd = mk(1'b1, 32'h8000_0010, 32'h1234, ControlFlow_Branch);
        @(negedge clk);
        chk("single_same_cycle", 67'(btb_upd), 67'(0));
        tick();
        idle();
        @(negedge clk);
        chk("single_write", 67'(btb_upd), 67'(mk(1'b1, 32'h8000_0010, 32'h1234, ControlFlow_Branch)));
        tick();
        @(negedge clk);
        chk("single_empty", 67'(btb_upd), 67'(0));

        // Coalesce: second commit to the same PC overwrites the target of the queued entry.
        tick();
        btb_ready  = 1'b0;
        commit_upd = mk(1'b1, 32'h8000_0020, 32'hA, ControlFlow_Jump);
        tick();
        commit_upd = mk(1'b1, 32'h8000_0020, 32'hB, ControlFlow_Jump);
        @(negedge clk);
        chk("coal_drop", 67'(drop), 67'(0));
        tick();
        idle();
        btb_ready = 1'b1;
        @(negedge clk);
        chk("coal_write", 67'(btb_upd), 67'(mk(1'b1, 32'h8000_0020, 32'hB, ControlFlow_Jump)));
        tick();
        @(negedge clk);
        chk("coal_once", 67'(btb_upd), 67'(0));

        // Dual source with one free slot, full-queue drop, merge while full, push into popped slot.
        tick();
        btb_ready    = 1'b0;
        presolve_upd = mk(1'b1, 32'h100, 32'h1, ControlFlow_Jump);
        tick();
        idle();
        commit_upd   = mk(1'b1, 32'h104, 32'h2, ControlFlow_Jump);
        tick();
        idle();
        presolve_upd = mk(1'b1, 32'h108, 32'h3, ControlFlow_Jump);
        tick();
        commit_upd   = mk(1'b1, 32'h200, 32'h4, ControlFlow_Jump);
        presolve_upd = mk(1'b1, 32'h204, 32'h5, ControlFlow_Jump);
        @(negedge clk);
        chk("dual_drop", 67'(drop), 67'(1));
        chk("dual_not_full_yet", 67'(queue_full), 67'(0));
        tick();
        idle();
        @(negedge clk);
        chk("dual_full", 67'(queue_full), 67'(1));
        chk("dual_drop_once", 67'(drop), 67'(0));
        tick();
        commit_upd = mk(1'b1, 32'h300, 32'h7, ControlFlow_Jump);
        @(negedge clk);
        chk("full_nomatch_drop", 67'(drop), 67'(1));
        tick();
        commit_upd = mk(1'b1, 32'h104, 32'h99, ControlFlow_Jump);
        @(negedge clk);
        chk("full_match_nodrop", 67'(drop), 67'(0));
        tick();
        idle();
        btb_ready    = 1'b1;
        presolve_upd = mk(1'b1, 32'h400, 32'h6, ControlFlow_Jump);
        @(negedge clk);
        chk("pop_frees_slot", 67'(drop), 67'(0));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            chk($sformatf("drain_%0d", i), 67'(btb_upd), 67'(mk(1'b1, exp_pc[i], exp_tgt[i], ControlFlow_Jump)));
            tick();
            idle();
        end
        @(negedge clk);
        chk("drain_empty", 67'(btb_upd), 67'(0));
        chk("drain_not_full", 67'(queue_full), 67'(0));

        // Request matching the head in its pop cycle becomes a new entry.
        tick();
        btb_ready  = 1'b0;
        commit_upd = mk(1'b1, 32'h500, 32'h1, ControlFlow_Return);
        tick();
        btb_ready  = 1'b1;
        commit_upd = mk(1'b1, 32'h500, 32'h2, ControlFlow_Return);
        @(negedge clk);
        chk("head_pop_old", 67'(btb_upd), 67'(mk(1'b1, 32'h500, 32'h1, ControlFlow_Return)));
        tick();
        idle();
        @(negedge clk);
        chk("head_pop_new", 67'(btb_upd), 67'(mk(1'b1, 32'h500, 32'h2, ControlFlow_Return)));
        tick();
        @(negedge clk);
        chk("head_pop_empty", 67'(btb_upd), 67'(0));

        // Same-PC collision between sources: one entry carrying commit's target.
        tick();
        btb_ready    = 1'b0;
        commit_upd   = mk(1'b1, 32'h8000_0040, 32'hCCCC, ControlFlow_Branch);
        presolve_upd = mk(1'b1, 32'h8000_0040, 32'hAAAA, ControlFlow_Jump);
        @(negedge clk);
        chk("same_pc_drop", 67'(drop), 67'(0));
        tick();
        idle();
        btb_ready = 1'b1;
        @(negedge clk);
        chk("same_pc_write", 67'(btb_upd), 67'(mk(1'b1, 32'h8000_0040, 32'hCCCC, ControlFlow_Branch)));
        tick();
        @(negedge clk);
        chk("same_pc_single", 67'(btb_upd), 67'(0));

        // Sweep with two queued entries and a request in the flush cycle.
        tick();
        btb_ready    = 1'b0;
        presolve_upd = mk(1'b1, 32'h600, 32'h1, ControlFlow_Jump);
        tick();
        idle();
        commit_upd   = mk(1'b1, 32'h604, 32'h2, ControlFlow_Jump);
        tick();
        btb_ready    = 1'b1;
        flush_req    = 1'b1;
        commit_upd   = mk(1'b1, 32'h700, 32'h3, ControlFlow_Jump);
        @(negedge clk);
        chk("flush_req_drop", 67'(drop), 67'(1));
        chk("flush_no_write", 67'(btb_upd), 67'(0));
        tick();
        idle();
        busy = 0;
        wr   = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            btb_ready = !(cyc >= 6 && cyc < 9);
            @(negedge clk);
            if (!flush_busy) begin
                break;
            end
            busy++;
            if (btb_upd.valid) begin
                chk($sformatf("sweep_wr_%0d", wr), 67'(btb_upd),
                    67'(mk(1'b1, 32'(wr * 4), 32'h0, ControlFlow_None)));
                wr++;
            end
            tick();
        end
        chk("sweep_writes", 67'(wr), 67'(16));
        chk("sweep_busy_cycles", 67'(busy), 67'(19));
        chk("sweep_queue_cleared", 67'(btb_upd), 67'(0));
        chk("sweep_not_full", 67'(queue_full), 67'(0));

        // Reset at sweep count 5: no write in the rst cycle, then idle RUN, then normal updates.
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sweep_no_write", 67'(btb_upd), 67'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sweep_busy", 67'(flush_busy), 67'(0));
        chk("rst_sweep_upd", 67'(btb_upd), 67'(0));
        chk("rst_sweep_full", 67'(queue_full), 67'(0));
        tick();
        presolve_upd = mk(1'b1, 32'h8000_0010, 32'h55, ControlFlow_Branch);
        @(negedge clk);
        chk("post_rst_drop", 67'(drop), 67'(0));
        tick();
        idle();
        @(negedge clk);
        chk("post_rst_write", 67'(btb_upd), 67'(mk(1'b1, 32'h8000_0010, 32'h55, ControlFlow_Branch)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
